mix_uart_rx: RTL

- Serial receiver that feeds the MIX card-reader input unit. It samples the asynchronous `rx` line and recovers 8N1 frames (LSB first).
- For each good frame it presents `out[7:0]` with a one-cycle `stop` strobe. The input unit treats that strobe as "byte ready" and then does the ASCII-to-MIX translation and word assembly.
- Adds metastability protection, majority-vote sampling, false-start rejection and framing-error/break handling.

---
 rtl/mix_uart_rx_if.sv | 22 ++
 rtl/mix_uart_rx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mix_uart_rx_if.sv
// Byte-side bundle of the MIX card-reader UART receiver: received byte and
// its status strobes, driven by the receiver (master) and read by the input unit.
interface mix_uart_rx_if;
  logic [7:0] out;
  logic       stop;
  logic       framing_error;
  logic       busy;

  modport master (
    output out,
    output stop,
    output framing_error,
    output busy
  );

  modport slave (
    input out,
    input stop,
    input framing_error,
    input busy
  );
endinterface

// File: rtl/mix_uart_rx.sv
// 8N1 serial receiver for the MIX card-reader input unit: synchronises rx,
// votes three samples per bit and strobes each good byte or framing error.
module mix_uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  mix_uart_rx_if.master bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic          rx_d;
  logic [1:0]    flush;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;
  logic          v0;
  logic          v1;

  logic maj;
  logic decide;
  logic last;

  assign maj    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);
  assign decide = (cnt == CW'(HALF + 1));
  assign last   = (cnt == CW'(CLKS_PER_BIT - 1));

  // rx_s comes out of reset as 1, so arming waits for the synchroniser to
  // flush; otherwise a line held low through reset would look like a start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m              <= 1'b1;
      rx_s              <= 1'b1;
      rx_d              <= 1'b1;
      flush             <= 2'b00;
      armed             <= 1'b0;
      state             <= IDLE;
      cnt               <= '0;
      idx               <= 3'd0;
      sh                <= 8'h00;
      v0                <= 1'b1;
      v1                <= 1'b1;
      bus.out           <= 8'h00;
      bus.stop          <= 1'b0;
      bus.framing_error <= 1'b0;
      bus.busy          <= 1'b0;
    end else begin
      rx_m              <= rx;
      rx_s              <= rx_m;
      rx_d              <= rx_s;
      flush             <= {flush[0], 1'b1};
      bus.stop          <= 1'b0;
      bus.framing_error <= 1'b0;

      if (state != IDLE) begin
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (cnt == CW'(HALF - 1)) begin
        v0 <= rx_s;
      end
      if (cnt == CW'(HALF)) begin
        v1 <= rx_s;
      end

      case (state)
        IDLE: begin
          bus.busy <= 1'b0;
          if (flush[1] && rx_s) begin
            armed <= 1'b1;
          end
          if (armed && rx_d && !rx_s) begin
            state    <= START;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end

        START: begin
          if (decide) begin
            if (maj) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= 3'd0;
            end
          end
        end

        DATA: begin
          if (decide) begin
            sh[idx] <= maj;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        // Returning to IDLE at the decision point leaves half a stop bit of
        // margin for a back-to-back start edge.
        STOP: begin
          if (decide) begin
            if (maj) begin
              bus.out  <= sh;
              bus.stop <= 1'b1;
              bus.busy <= 1'b0;
              state    <= IDLE;
            end else begin
              bus.framing_error <= 1'b1;
              state             <= BRK;
            end
          end
        end

        BRK: begin
          if (rx_s) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
